mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage memory access controller for the kanade32 pipeline. It sits between the EX/MEM stage register outputs and the data bus. It turns each load or store flagged in the EX/MEM stage into one word-aligned, byte-enabled bus transaction with a req/ack handshake, and stalls the pipeline until that transaction completes. Load data is aligned and extended here, then presented to the MEM/WB stage register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without bus_ack before the access is abandoned.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- mem_read  in  1  EX/MEM load flag
- mem_write  in  1  EX/MEM store flag
- acc_mode  in  3  access mode: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5-7 are treated as word
- addr  in  32  byte address (EX/MEM ALU result)
- wdata  in  32  store data; the value sits in the low bits
- hold  in  1  pipeline is held by another stall source, so EX/MEM does not advance
- stall  out  1  pipeline hold request; PC and all stage-register wren are driven by !stall && !hold
- mem_data  out  32  aligned, extended load result
- addr_err  out  1  one-cycle pulse: misaligned access
- bus_err  out  1  one-cycle pulse: bus timeout
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address; bits [1:0] are always 0
- bus_be  out  4  byte enables; bit n corresponds to byte lane [8n+7:8n]
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; rdata is valid in the same cycle
- bus_rdata  in  32  bus read data

## Operation
States are IDLE, BUSY and DONE.
- **access**: mem_read or mem_write. If both are asserted, the access is treated as a store.
- **Misaligned access**:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - byte accesses are never misaligned.
- **IDLE**, no access: stall=0 and no bus activity.
- **IDLE**, access present: stall=1.
  - Aligned access: register bus_addr, bus_be, bus_wdata and bus_we, then go to BUSY.
  - Misaligned access: go to DONE with mem_data=0 and addr_err=1. No bus cycle occurs and the store is suppressed.
- **BUSY**: bus_req=1 and stall=1. bus_addr, bus_be, bus_wdata and bus_we are held stable.
  - On bus_ack: latch the formatted load into mem_data (mem_data=0 for a store), drop bus_req and go to DONE.
  - On timeout: the cycle counter reaches TIMEOUT_CYCLES without an ack. Drop bus_req, set mem_data=0, pulse bus_err and go to DONE.
  - If bus_ack arrives in the same cycle the counter expires, the ack wins.
- **DONE**: stall=0 and mem_data is held.
  - hold=0: go to IDLE. The pipeline advances on this edge and MEM/WB captures mem_data.
  - hold=1: stay in DONE. A new access is not started.
- **Byte enables**:
  - byte access: 1 << addr[1:0];
  - half access: addr[1] ? 4'b1100 : 4'b0011;
  - word access: 4'b1111.
- **Store lane replication**:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- **Load extraction** (little-endian): shift bus_rdata right by addr[1:0]*8, then:
  - byte: sign- or zero-extend bits [7:0] according to mode;
  - half: sign- or zero-extend bits [15:0] according to mode.

## Timing
- **Reset values**: state IDLE, stall=0, mem_data=0, addr_err=0, bus_err=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, timeout counter 0.
- **Reset mid-access**: bus_req drops at the reset edge. The in-flight transaction is abandoned, and no result or error is reported.
- stall is combinational from state and access. It is 1 in IDLE-with-access and in BUSY.
- **Minimum latency** (ack in the first BUSY cycle): 3 cycles. Cycle 0 is IDLE with stall=1, cycle 1 is BUSY, cycle 2 is DONE with stall=0 and the pipeline advances at its end.
- Each additional wait state before ack adds one cycle.
- **Misaligned access**: 2 cycles (IDLE, then DONE).
- Non-memory instructions pay no penalty.
- bus_req is a registered output, high exactly during BUSY cycles. It never deasserts before ack or timeout.
- Exactly one bus transaction is issued per memory instruction, including when the same EX/MEM contents are seen across stall cycles.

## Test plan
- **lw**: addr 0x100, rdata 0x11223344, ack in the first BUSY cycle. Expect stall high for 2 cycles, bus_be=1111, bus_addr=0x100 and mem_data=0x11223344 in DONE.
- **lb**: addr 0x103, rdata 0x80FFFFFF. Signed mode gives mem_data 0xFFFFFF80 with bus_be 1000; unsigned mode gives 0x00000080.
- **sh**: addr 0x102, wdata 0x0000BEEF. Expect bus_we=1, bus_be 1100, bus_wdata 0xBEEFBEEF and exactly one req.
- **Misaligned word load**: addr 0x101. Expect addr_err pulse, no bus_req, mem_data 0 and stall for 1 cycle only.
- **Ack delayed 4 cycles, and timeout**:
  - ack delayed 4 cycles: bus outputs stay stable and stall lasts 6 cycles;
  - TIMEOUT_CYCLES=8 with no ack: bus_err pulses after 8 BUSY cycles and mem_data=0.
- **hold=1 in DONE for 3 cycles**: DONE persists and no new req is issued. Separately, reset_n=0 in BUSY: bus_req=0 and stall=0 on the next cycle.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage access unit (master) and the memory system (slave).
// Single-beat req/ack handshake; read data is valid in the ack cycle.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// kanade32 MEM-stage access unit: one word-aligned, byte-enabled bus transaction per load/store,
// pipeline stall until completion, load alignment and extension toward MEM/WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        acc_mode,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              hold,
    output logic              stall,
    output logic [31:0]       mem_data,
    output logic              addr_err,
    output logic              bus_err,
    mem_access_unit_if.master bus
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; the expiring cycle is detected by compare.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      off_q, off_d;
    logic            byte_q, byte_d;
    logic            half_q, half_d;
    logic            sign_q, sign_d;
    logic [31:0]     mem_data_q, mem_data_d;
    logic            addr_err_q, addr_err_d;
    logic            bus_err_q, bus_err_d;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_signed;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] shifted;
    logic [31:0] load_fmt;

    assign access = mem_read | mem_write;

    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (acc_mode)
            3'd1: begin
                is_half   = 1'b1;
                is_signed = 1'b1;
            end
            3'd2: is_half = 1'b1;
            3'd3: begin
                is_byte   = 1'b1;
                is_signed = 1'b1;
            end
            3'd4: is_byte = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = wdata;
        if (is_byte) begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
        end else if (is_half) begin
            misaligned = addr[0];
            be_new     = addr[1] ? 4'b1100 : 4'b0011;
            wdata_new  = {2{wdata[15:0]}};
        end else begin
            misaligned = |addr[1:0];
        end
    end

    // Little-endian extraction uses the offset and mode captured when the access was issued.
    always_comb begin
        shifted  = bus.bus_rdata >> {off_q, 3'b000};
        load_fmt = shifted;
        if (byte_q) begin
            load_fmt = {{24{sign_q & shifted[7]}}, shifted[7:0]};
        end else if (half_q) begin
            load_fmt = {{16{sign_q & shifted[15]}}, shifted[15:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        byte_d     = byte_q;
        half_d     = half_q;
        sign_d     = sign_q;
        mem_data_d = mem_data_q;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        stall      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (access) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        state_d    = StDone;
                        mem_data_d = 32'h0;
                        addr_err_d = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        off_d   = addr[1:0];
                        byte_d  = is_byte;
                        half_d  = is_half;
                        sign_d  = is_signed;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    state_d    = StDone;
                    req_d      = 1'b0;
                    mem_data_d = we_q ? 32'h0 : load_fmt;
                end else if (cnt_q == CntLast) begin
                    state_d    = StDone;
                    req_d      = 1'b0;
                    mem_data_d = 32'h0;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (!hold) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            off_q      <= 2'b00;
            byte_q     <= 1'b0;
            half_q     <= 1'b0;
            sign_q     <= 1'b0;
            mem_data_q <= 32'h0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            byte_q     <= byte_d;
            half_q     <= half_d;
            sign_q     <= sign_d;
            mem_data_q <= mem_data_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign mem_data      = mem_data_q;
    assign addr_err      = addr_err_q;
    assign bus_err       = bus_err_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, wait states, timeout, hold and
// reset mid-access, with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  acc_mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        stall;
    logic [31:0] mem_data;
    logic        addr_err;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .acc_mode (acc_mode),
        .addr     (addr),
        .wdata    (wdata),
        .hold     (hold),
        .stall    (stall),
        .mem_data (mem_data),
        .addr_err (addr_err),
        .bus_err  (bus_err),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bus slave: acks after ack_delay wait states, counts request rising edges.
    bit          ack_en    = 1'b1;
    int          ack_delay = 0;
    logic [31:0] rdata_val = 32'h0;
    int          wait_cnt  = 0;
    int          req_count = 0;
    logic        req_prev  = 1'b0;

    assign bus.bus_rdata = rdata_val;

    always @(negedge clk) begin
        if (bus.bus_req && !req_prev) req_count++;
        req_prev = bus.bus_req;
        if (bus.bus_req && ack_en) begin
            if (wait_cnt == ack_delay) begin
                bus.bus_ack = 1'b1;
                wait_cnt    = 0;
            end else begin
                bus.bus_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.bus_ack = 1'b0;
            wait_cnt    = 0;
        end
    end

    int          n_stall;
    int          n_busy;
    bit          unstable;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic        s_we;

    // Entered just after a negedge with the DUT idle; returns in the first non-stalled cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] mode,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd_val);
        rdata_val = rd_val;
        req_count = 0;
        n_stall   = 0;
        n_busy    = 0;
        unstable  = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        acc_mode  = mode;
        addr      = a;
        wdata     = wd;
        #1;
        for (int i = 0; i < 40 && stall; i++) begin
            n_stall++;
            if (bus.bus_req) begin
                if (n_busy == 0) begin
                    s_addr  = bus.bus_addr;
                    s_wdata = bus.bus_wdata;
                    s_be    = bus.bus_be;
                    s_we    = bus.bus_we;
                end else if (s_addr !== bus.bus_addr || s_wdata !== bus.bus_wdata ||
                             s_be !== bus.bus_be || s_we !== bus.bus_we) begin
                    unstable = 1'b1;
                end
                n_busy++;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic finish_access();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_done(input string tag, input int stalls, input int busy,
                               input logic [3:0] be, input logic [31:0] a,
                               input logic [31:0] wd, input logic we, input logic [31:0] md,
                               input logic aerr, input logic berr);
        check({tag, " stall_cycles"}, 32'(n_stall), 32'(stalls));
        check({tag, " busy_cycles"}, 32'(n_busy), 32'(busy));
        check({tag, " req_count"}, 32'(req_count), (busy > 0) ? 32'd1 : 32'd0);
        if (busy > 0) begin
            check({tag, " bus_be"}, 32'(s_be), 32'(be));
            check({tag, " bus_addr"}, s_addr, a);
            check({tag, " bus_wdata"}, s_wdata, wd);
            check({tag, " bus_we"}, 32'(s_we), 32'(we));
            check({tag, " bus_stable"}, 32'(unstable), 32'd0);
        end
        check({tag, " mem_data"}, mem_data, md);
        check({tag, " addr_err"}, 32'(addr_err), 32'(aerr));
        check({tag, " bus_err"}, 32'(bus_err), 32'(berr));
        check({tag, " req_in_done"}, 32'(bus.bus_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit spurious;
        reset_n   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        acc_mode  = 3'd0;
        addr      = 32'h0;
        wdata     = 32'h0;
        hold      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst mem_data", mem_data, 32'h0);
        check("rst addr_err", 32'(addr_err), 32'd0);
        check("rst bus_err", 32'(bus_err), 32'd0);
        check("rst bus_req", 32'(bus.bus_req), 32'd0);
        check("rst bus_we", 32'(bus.bus_we), 32'd0);
        check("rst bus_addr", bus.bus_addr, 32'h0);
        check("rst bus_be", 32'(bus.bus_be), 32'h0);
        check("rst bus_wdata", bus.bus_wdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle no access stall", 32'(stall), 32'd0);

        do_access(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h11223344);
        expect_done("lw", 2, 1, 4'b1111, 32'h100, 32'h0, 1'b0, 32'h11223344, 1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 32'h80FFFFFF);
        expect_done("lb", 2, 1, 4'b1000, 32'h100, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF);
        expect_done("lbu", 2, 1, 4'b1000, 32'h100, 32'h0, 1'b0, 32'h00000080, 1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h8001ABCD);
        expect_done("lhu", 2, 1, 4'b1100, 32'h100, 32'h0, 1'b0, 32'h00008001, 1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h8001ABCD);
        expect_done("lh", 2, 1, 4'b1100, 32'h100, 32'h0, 1'b0, 32'hFFFF8001, 1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 32'h0);
        expect_done("lw misaligned", 1, 0, 4'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        finish_access();
        check("addr_err one cycle", 32'(addr_err), 32'd0);

        do_access(1'b1, 1'b0, 3'd6, 32'h104, 32'h0, 32'hA5A50F0F);
        expect_done("mode6 as word", 2, 1, 4'b1111, 32'h104, 32'h0, 1'b0, 32'hA5A50F0F,
                    1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b0, 3'd7, 32'h102, 32'h0, 32'h0);
        expect_done("mode7 misaligned", 1, 0, 4'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        finish_access();

        do_access(1'b0, 1'b1, 3'd1, 32'h102, 32'h0000BEEF, 32'hDEADBEEF);
        expect_done("sh", 2, 1, 4'b1100, 32'h100, 32'hBEEFBEEF, 1'b1, 32'h0, 1'b0, 1'b0);
        finish_access();

        do_access(1'b0, 1'b1, 3'd4, 32'h101, 32'h0000005A, 32'h0);
        expect_done("sb", 2, 1, 4'b0010, 32'h100, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0, 1'b0);
        finish_access();

        do_access(1'b1, 1'b1, 3'd0, 32'h300, 32'h12345678, 32'hFFFFFFFF);
        expect_done("rd+wr store", 2, 1, 4'b1111, 32'h300, 32'h12345678, 1'b1, 32'h0,
                    1'b0, 1'b0);
        finish_access();

        do_access(1'b0, 1'b1, 3'd2, 32'h103, 32'h1234, 32'h0);
        expect_done("sh misaligned", 1, 0, 4'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        finish_access();

        ack_delay = 4;
        do_access(1'b1, 1'b0, 3'd0, 32'h200, 32'h0, 32'hCAFEF00D);
        expect_done("lw wait4", 6, 5, 4'b1111, 32'h200, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
        finish_access();
        ack_delay = 0;

        ack_en = 1'b0;
        do_access(1'b1, 1'b0, 3'd0, 32'h204, 32'h0, 32'h77777777);
        expect_done("timeout", 9, 8, 4'b1111, 32'h204, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        finish_access();
        check("bus_err one cycle", 32'(bus_err), 32'd0);
        ack_en = 1'b1;

        do_access(1'b1, 1'b0, 3'd0, 32'h108, 32'h0, 32'h0BADCAFE);
        expect_done("hold lw", 2, 1, 4'b1111, 32'h108, 32'h0, 1'b0, 32'h0BADCAFE, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("hold stall", 32'(stall), 32'd0);
            check("hold bus_req", 32'(bus.bus_req), 32'd0);
            check("hold mem_data", mem_data, 32'h0BADCAFE);
        end
        hold = 1'b0;
        finish_access();
        check("hold req_count", 32'(req_count), 32'd1);
        check("after hold stall", 32'(stall), 32'd0);

        ack_en    = 1'b0;
        req_count = 0;
        mem_read  = 1'b1;
        acc_mode  = 3'd0;
        addr      = 32'h10C;
        @(negedge clk);
        #1;
        check("pre-reset bus_req", 32'(bus.bus_req), 32'd1);
        reset_n  = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        check("reset busy bus_req", 32'(bus.bus_req), 32'd0);
        check("reset busy stall", 32'(stall), 32'd0);
        check("reset busy mem_data", mem_data, 32'h0);
        reset_n  = 1'b1;
        ack_en   = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (bus_err || addr_err || bus.bus_req || stall) spurious = 1'b1;
        end
        check("post-reset quiet", 32'(spurious), 32'd0);
        check("post-reset req_count", 32'(req_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
